// File: rtl/game_ctrl_pkg.sv
// Shared game constants: state encoding consumed by the gameplay datapaths,
// life/score limits and the obstacle period helper.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'b00,
    GS_RUN   = 2'b01,
    GS_OVER  = 2'b10,
    GS_CLEAN = 2'b11
  } game_state_e;

  localparam int unsigned START_LIVES = 3;
  localparam int unsigned SCORE_MAX   = 999;
  localparam int unsigned PERIOD_W    = 25;

  // Level 0 plays as 1, anything above 9 plays as 9.
  function automatic logic [3:0] eff_level(input logic [3:0] lvl);
    if (lvl == 4'd0) return 4'd1;
    if (lvl > 4'd9) return 4'd9;
    return lvl;
  endfunction

  // Signed arithmetic keeps base - (lvl-1)*step from wrapping before the floor clamp.
  function automatic logic [PERIOD_W-1:0] obst_period(input logic [3:0]          eff,
                                                      input logic [PERIOD_W-1:0] base,
                                                      input logic [PERIOD_W-1:0] step,
                                                      input logic [PERIOD_W-1:0] floor_p);
    logic signed [25:0] s_lvl;
    logic signed [25:0] s_per;
    s_lvl = $signed({22'd0, eff}) - 26'sd1;
    s_per = $signed({1'b0, base}) - (s_lvl * $signed({1'b0, step}));
    if (s_per < $signed({1'b0, floor_p})) s_per = $signed({1'b0, floor_p});
    return s_per[PERIOD_W-1:0];
  endfunction

endpackage

// File: rtl/game_ctrl_tick_gen.sv
// Periodic one-cycle strobe; the counter holds at zero while disabled so each
// enable window starts a fresh period.
module tick_gen
  import game_ctrl_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_En,
  input  logic [PERIOD_W-1:0] i_Period,
  output logic                o_Tick
);

  logic [PERIOD_W-1:0] r_Count;
  logic                r_Tick;
  logic                w_Wrap;

  assign w_Wrap = (r_Count == (i_Period - PERIOD_W'(1)));

  always_ff @(posedge i_Clk) begin
    if (i_Rst || !i_En) begin
      r_Count <= '0;
      r_Tick  <= 1'b0;
    end else if (w_Wrap) begin
      r_Count <= '0;
      r_Tick  <= 1'b1;
    end else begin
      r_Count <= r_Count + PERIOD_W'(1);
      r_Tick  <= 1'b0;
    end
  end

  assign o_Tick = r_Tick;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/CLEAN/RUN/OVER flow, lives and score bookkeeping, and
// the move/obstacle strobes that only run while in RUN.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned CLEAN_CYCLES = 12_500_000,
  parameter int unsigned MOVE_PERIOD  = 4_194_304,
  parameter int unsigned OBST_BASE    = 2_097_152,
  parameter int unsigned OBST_STEP    = 131_072,
  parameter int unsigned OBST_MIN     = 524_288,
  parameter int unsigned START_LIVES  = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Collision,
  input  logic       i_Reached_Top,
  input  logic [3:0] i_Level,
  output logic [1:0] o_Game_State,
  output logic [1:0] o_Lives,
  output logic [9:0] o_Score,
  output logic       o_Move_Tick,
  output logic       o_Obst_Tick
);

  localparam logic [PERIOD_W-1:0] CLEAN_LAST = PERIOD_W'(CLEAN_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] MOVE_P     = PERIOD_W'(MOVE_PERIOD);
  localparam logic [PERIOD_W-1:0] OBST_B     = PERIOD_W'(OBST_BASE);
  localparam logic [PERIOD_W-1:0] OBST_S     = PERIOD_W'(OBST_STEP);
  localparam logic [PERIOD_W-1:0] OBST_M     = PERIOD_W'(OBST_MIN);
  localparam logic [1:0]          LIVES_INIT = 2'(START_LIVES);
  localparam logic [10:0]         SCORE_SAT  = 11'(SCORE_MAX);

  game_state_e         r_State, w_State_D;
  logic [1:0]          r_Lives, w_Lives_D;
  logic [9:0]          r_Score, w_Score_D;
  logic                r_Start_Prev;
  logic [PERIOD_W-1:0] r_Clean_Cnt;
  logic [PERIOD_W-1:0] r_Obst_Period;
  logic                w_Start_Edge;
  logic [3:0]          w_Eff_Level;
  logic [10:0]         w_Score_Sum;
  logic                w_Run_Next;
  logic                w_Run_Entry;
  logic                w_Move_Tick;
  logic                w_Obst_Tick;

  assign w_Start_Edge = i_Start && !r_Start_Prev;
  assign w_Eff_Level  = eff_level(i_Level);
  assign w_Score_Sum  = {1'b0, r_Score} + {7'd0, w_Eff_Level};
  assign w_Run_Next   = (w_State_D == GS_RUN);
  assign w_Run_Entry  = w_Run_Next && (r_State != GS_RUN);

  always_comb begin
    w_State_D = r_State;
    w_Lives_D = r_Lives;
    w_Score_D = r_Score;
    case (r_State)
      GS_IDLE, GS_OVER: begin
        if (w_Start_Edge) begin
          w_State_D = GS_CLEAN;
          w_Lives_D = LIVES_INIT;
          w_Score_D = '0;
        end
      end
      GS_CLEAN: begin
        if (r_Clean_Cnt == CLEAN_LAST) w_State_D = GS_RUN;
      end
      GS_RUN: begin
        // Collision outranks reaching the top; no score when both fire.
        if (i_Collision) begin
          w_Lives_D = r_Lives - 2'd1;
          w_State_D = (r_Lives == 2'd1) ? GS_OVER : GS_CLEAN;
        end else if (i_Reached_Top) begin
          w_Score_D = (w_Score_Sum > SCORE_SAT) ? SCORE_SAT[9:0] : w_Score_Sum[9:0];
          w_State_D = GS_CLEAN;
        end
      end
      default: w_State_D = GS_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State       <= GS_IDLE;
      r_Lives       <= LIVES_INIT;
      r_Score       <= '0;
      r_Start_Prev  <= 1'b0;
      r_Clean_Cnt   <= '0;
      r_Obst_Period <= OBST_B;
    end else begin
      r_State      <= w_State_D;
      r_Lives      <= w_Lives_D;
      r_Score      <= w_Score_D;
      r_Start_Prev <= i_Start;
      r_Clean_Cnt  <= (r_State == GS_CLEAN && w_State_D == GS_CLEAN) ?
                      r_Clean_Cnt + PERIOD_W'(1) : '0;
      // Relatching only at RUN entry or a wrap keeps a period in flight intact.
      if (w_Run_Entry || w_Obst_Tick) begin
        r_Obst_Period <= obst_period(w_Eff_Level, OBST_B, OBST_S, OBST_M);
      end
    end
  end

  tick_gen u_move_tick (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_En     (w_Run_Next),
    .i_Period (MOVE_P),
    .o_Tick   (w_Move_Tick)
  );

  tick_gen u_obst_tick (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_En     (w_Run_Next),
    .i_Period (r_Obst_Period),
    .o_Tick   (w_Obst_Tick)
  );

  assign o_Game_State = r_State;
  assign o_Lives      = r_Lives;
  assign o_Score      = r_Score;
  assign o_Move_Tick  = w_Move_Tick;
  assign o_Obst_Tick  = w_Obst_Tick;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected state transitions and
// tick cycles, a negedge monitor pops and compares as the DUT produces them.
module tb_game_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Start = 1'b0;
  logic       i_Collision = 1'b0;
  logic       i_Reached_Top = 1'b0;
  logic [3:0] i_Level = 4'd1;
  logic [1:0] o_Game_State;
  logic [1:0] o_Lives;
  logic [9:0] o_Score;
  logic       o_Move_Tick;
  logic       o_Obst_Tick;

  game_ctrl #(
    .CLEAN_CYCLES (4),
    .MOVE_PERIOD  (8),
    .OBST_BASE    (20),
    .OBST_STEP    (4),
    .OBST_MIN     (8),
    .START_LIVES  (3)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Start       (i_Start),
    .i_Collision   (i_Collision),
    .i_Reached_Top (i_Reached_Top),
    .i_Level       (i_Level),
    .o_Game_State  (o_Game_State),
    .o_Lives       (o_Lives),
    .o_Score       (o_Score),
    .o_Move_Tick   (o_Move_Tick),
    .o_Obst_Tick   (o_Obst_Tick)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int cyc;
    int st;
    int lives;
    int score;
  } exp_t;

  exp_t exp_q[$];
  int   mv_q[$];
  int   ob_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  bit   tick_en = 1'b0;
  logic [1:0] prev_st = 2'bxx;
  int   m_lives = 3;
  int   m_score = 0;
  exp_t e;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic bad(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  always @(negedge i_Clk) begin
    if (mon_en) begin
      if (o_Game_State !== prev_st) begin
        if (exp_q.size() == 0) bad("unexpected_state_change");
        else begin
          e = exp_q.pop_front();
          chk("state", int'(o_Game_State), e.st);
          chk("state_cycle", cyc, e.cyc);
          chk("lives", int'(o_Lives), e.lives);
          chk("score", int'(o_Score), e.score);
        end
      end
      if (tick_en && o_Move_Tick) begin
        if (mv_q.size() == 0) bad("unexpected_move_tick");
        else chk("move_tick_cycle", cyc, mv_q.pop_front());
      end
      if (tick_en && o_Obst_Tick) begin
        if (ob_q.size() == 0) bad("unexpected_obst_tick");
        else chk("obst_tick_cycle", cyc, ob_q.pop_front());
      end
    end
    prev_st <= o_Game_State;
  end

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  function automatic int eff(input int lvl);
    if (lvl == 0) return 1;
    if (lvl > 9) return 9;
    return lvl;
  endfunction

  function automatic int operiod(input int lvl);
    int p;
    p = 20 - (eff(lvl) - 1) * 4;
    return (p < 8) ? 8 : p;
  endfunction

  function automatic exp_t mk(input int c, input int st, input int lv, input int sc);
    exp_t r;
    r.cyc = c; r.st = st; r.lives = lv; r.score = sc;
    return r;
  endfunction

  task automatic start_pulse();
    int k;
    k = cyc;
    m_lives = 3;
    m_score = 0;
    exp_q.push_back(mk(k + 1, 3, 3, 0));
    exp_q.push_back(mk(k + 5, 1, 3, 0));
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
  endtask

  // Issued while in RUN; collision/top held for `hold` cycles.
  task automatic event_run(input bit coll, input bit top, input int lvl, input int hold);
    int k;
    k = cyc;
    i_Level = 4'(lvl);
    if (coll) begin
      m_lives--;
      if (m_lives == 0) exp_q.push_back(mk(k + 1, 2, 0, m_score));
      else begin
        exp_q.push_back(mk(k + 1, 3, m_lives, m_score));
        exp_q.push_back(mk(k + 5, 1, m_lives, m_score));
      end
    end else if (top) begin
      m_score = m_score + eff(lvl);
      if (m_score > 999) m_score = 999;
      exp_q.push_back(mk(k + 1, 3, m_lives, m_score));
      exp_q.push_back(mk(k + 5, 1, m_lives, m_score));
    end
    i_Collision = coll;
    i_Reached_Top = top;
    repeat (hold) step();
    i_Collision = 1'b0;
    i_Reached_Top = 1'b0;
  endtask

  task automatic run_obst(input int l_entry, input int l_mid);
    int h, p1, p2, fin;
    h = cyc;
    p1 = operiod(l_entry);
    p2 = operiod(l_mid);
    fin = h + 4 + p1 + 2 * p2 + 1;
    event_run(1'b0, 1'b1, l_entry, 1);
    ob_q.push_back(h + 4 + p1);
    ob_q.push_back(h + 4 + p1 + p2);
    ob_q.push_back(h + 4 + p1 + 2 * p2);
    for (int t = h + 12; t < fin; t += 8) mv_q.push_back(t);
    tick_en = 1'b1;
    wait_to(h + 10);
    i_Level = 4'(l_mid);
    wait_to(fin);
    tick_en = 1'b0;
    chk("obst_ticks_missing", ob_q.size(), 0);
    chk("move_ticks_missing", mv_q.size(), 0);
    ob_q.delete();
    mv_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, r;
    step();
    step();
    @(negedge i_Clk);
    chk("reset_state", int'(o_Game_State), 0);
    chk("reset_lives", int'(o_Lives), 3);
    chk("reset_score", int'(o_Score), 0);
    chk("reset_move_tick", int'(o_Move_Tick), 0);
    chk("reset_obst_tick", int'(o_Obst_Tick), 0);
    step();
    i_Rst = 1'b0;
    mon_en = 1'b1;
    step();
    step();

    // Start from IDLE, first ticks after RUN entry.
    c = cyc;
    mv_q.push_back(c + 12);
    mv_q.push_back(c + 20);
    mv_q.push_back(c + 28);
    ob_q.push_back(c + 24);
    tick_en = 1'b1;
    start_pulse();
    wait_to(c + 34);
    tick_en = 1'b0;
    chk("first_move_ticks_missing", mv_q.size(), 0);
    chk("first_obst_ticks_missing", ob_q.size(), 0);

    // Three collision events of 3 cycles each, down to OVER.
    d = cyc;
    event_run(1'b1, 1'b0, 1, 3);
    wait_to(d + 8);
    event_run(1'b1, 1'b0, 1, 3);
    wait_to(d + 16);
    event_run(1'b1, 1'b0, 1, 3);
    tick_en = 1'b1;
    wait_to(d + 31);
    tick_en = 1'b0;
    start_pulse();
    wait_to(d + 40);

    // Collision and top together: collision only.
    event_run(1'b1, 1'b1, 4, 1);
    wait_to(d + 45);

    // Score saturation at level 9.
    for (int n = 0; n < 112; n++) begin
      c = cyc;
      event_run(1'b0, 1'b1, 9, 1);
      wait_to(c + 5);
    end

    // Obstacle spacing with mid-period level changes.
    run_obst(1, 5);
    run_obst(3, 3);
    run_obst(9, 9);
    run_obst(5, 1);

    // Reset mid-RUN with start held high through reset.
    wait_to(cyc + 3);
    r = cyc;
    exp_q.push_back(mk(r + 1, 0, 3, 0));
    i_Rst = 1'b1;
    i_Start = 1'b1;
    step();
    tick_en = 1'b1;
    step();
    i_Rst = 1'b0;
    m_lives = 3;
    m_score = 0;
    exp_q.push_back(mk(r + 3, 3, 3, 0));
    exp_q.push_back(mk(r + 7, 1, 3, 0));
    wait_to(r + 7);
    tick_en = 1'b0;

    // Level 0 adds 1, level 12 adds 9; a start edge in RUN changes nothing.
    event_run(1'b0, 1'b1, 0, 1);
    wait_to(r + 12);
    event_run(1'b0, 1'b1, 12, 1);
    wait_to(r + 17);
    i_Start = 1'b0;
    step();
    i_Start = 1'b1;
    step();
    wait_to(r + 26);
    chk("expected_transitions_missing", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
